// File: rtl/flit_source.sv
// flit_source: credit-based flit injector. Serialises packet requests
// into head/body/tail flits on a registered router input channel.
// Ports: clk, reset (sync, active-low), pkt_valid/pkt_ready/pkt_vc/
// pkt_length/pkt_route request port, channel out, flow_ctrl credit
// return in, sent_flits_count out, sticky error out.
module flit_source #(
  parameter int num_vcs           = 8,
  parameter int buffer_size       = 64,
  parameter int max_packet_length = 4,
  parameter int route_info_width  = 14,
  parameter int enable_link_pm    = 1,
  parameter int flit_data_width   = 64,
  localparam int vc_idx_width =
    (num_vcs > 1) ? $clog2(num_vcs) : 1,
  localparam int len_width =
    $clog2(max_packet_length + 1),
  localparam int channel_width =
    enable_link_pm + 3 + vc_idx_width + flit_data_width
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pkt_valid,
  output logic                        pkt_ready,
  input  logic [vc_idx_width-1:0]     pkt_vc,
  input  logic [len_width-1:0]        pkt_length,
  input  logic [route_info_width-1:0] pkt_route,
  output logic [channel_width-1:0]    channel,
  input  logic [vc_idx_width:0]       flow_ctrl,
  output logic [31:0]                 sent_flits_count,
  output logic                        error
);

  localparam int cpv = buffer_size / num_vcs;
  localparam int cw  = $clog2(cpv + 1);
  localparam logic [cw-1:0] cpv_c = cw'(cpv);
  localparam logic [len_width-1:0] max_len =
    len_width'(max_packet_length);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                      state;
  logic [vc_idx_width-1:0]     cur_vc;
  logic [len_width-1:0]        cur_len;
  logic [len_width-1:0]        flit_idx;
  logic [route_info_width-1:0] cur_route;
  logic [15:0]                 pkt_cnt;

  logic [num_vcs-1:0][cw-1:0] credit_count;
  logic [num_vcs-1:0][cw-1:0] credit_nxt;
  logic [num_vcs-1:0]         ret_hit;
  logic [num_vcs-1:0]         snd_hit;

  logic                       ch_link;
  logic                       ch_valid;
  logic                       ch_head;
  logic                       ch_tail;
  logic [vc_idx_width-1:0]    ch_vc;
  logic [flit_data_width-1:0] ch_data;
  logic [flit_data_width-1:0] data_d;

  logic                    send_ok;
  logic                    last;
  logic                    len_bad;
  logic                    ovf;
  logic                    req_bad;
  logic [vc_idx_width-1:0] ret_vc;

  assign pkt_ready = (state == IDLE);
  assign ret_vc    = flow_ctrl[vc_idx_width:1];
  assign send_ok   = (state == SEND) &&
                     (credit_count[cur_vc] != '0);
  assign last      = (flit_idx == cur_len - len_width'(1));
  assign len_bad   = (pkt_length == '0) ||
                     (pkt_length > max_len);
  assign req_bad   = pkt_valid && pkt_ready && len_bad;

  always_comb begin
    data_d = '0;
    if (flit_idx == '0) begin
      data_d[flit_data_width-1 -: route_info_width] = cur_route;
    end else begin
      data_d[15:0]  = 16'(flit_idx);
      data_d[31:16] = pkt_cnt;
    end
  end

  // A send and a return on the same VC cancel out; a lone return
  // against a full counter is an overflow and leaves it at CPV.
  always_comb begin
    credit_nxt = credit_count;
    ovf        = 1'b0;
    for (int v = 0; v < num_vcs; v++) begin
      ret_hit[v] = flow_ctrl[0] &&
                   (ret_vc == vc_idx_width'(v));
      snd_hit[v] = send_ok &&
                   (cur_vc == vc_idx_width'(v));
      if (ret_hit[v] && !snd_hit[v]) begin
        if (credit_count[v] == cpv_c)
          ovf = 1'b1;
        else
          credit_nxt[v] = credit_count[v] + cw'(1);
      end else if (snd_hit[v] && !ret_hit[v]) begin
        credit_nxt[v] = credit_count[v] - cw'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      cur_vc           <= '0;
      cur_len          <= '0;
      cur_route        <= '0;
      flit_idx         <= '0;
      pkt_cnt          <= '0;
      credit_count     <= {num_vcs{cpv_c}};
      ch_link          <= 1'b0;
      ch_valid         <= 1'b0;
      ch_vc            <= '0;
      ch_head          <= 1'b0;
      ch_tail          <= 1'b0;
      ch_data          <= '0;
      sent_flits_count <= '0;
      error            <= 1'b0;
    end else begin
      credit_count <= credit_nxt;
      ch_link      <= (state == SEND);
      ch_valid     <= send_ok;
      ch_vc        <= send_ok ? cur_vc : '0;
      ch_head      <= send_ok && (flit_idx == '0);
      ch_tail      <= send_ok && last;
      ch_data      <= send_ok ? data_d : '0;
      if (send_ok)
        sent_flits_count <= sent_flits_count + 32'd1;
      if (ovf || req_bad)
        error <= 1'b1;
      unique case (state)
        IDLE: begin
          if (pkt_valid && !len_bad) begin
            cur_vc    <= pkt_vc;
            cur_len   <= pkt_length;
            cur_route <= pkt_route;
            flit_idx  <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (send_ok) begin
            if (last) begin
              pkt_cnt <= pkt_cnt + 16'd1;
              state   <= IDLE;
            end else begin
              flit_idx <= flit_idx + len_width'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if (enable_link_pm != 0) begin : g_lpm
    assign channel = {ch_link, ch_valid, ch_vc,
                      ch_head, ch_tail, ch_data};
  end else begin : g_nolpm
    assign channel = {ch_valid, ch_vc,
                      ch_head, ch_tail, ch_data};
  end

endmodule
